// File: rtl/rtc_cmd_if.sv
// Byte-stream link between spi_slave (master side) and rtc_cmd_engine (slave side).
interface rtc_cmd_if;
  logic       sel;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_halt;

  modport master (output sel, rx_data, rx_dv, tx_halt, input tx_data, tx_we);
  modport slave  (input sel, rx_data, rx_dv, tx_halt, output tx_data, tx_we);
endinterface

// File: rtl/rtc_cmd_engine.sv
// Epoch counter with alarm compare channels and a byte-stream command decoder.
// Every received byte (while sel is high) queues exactly one response byte.
module rtc_cmd_engine #(
  parameter int unsigned EPOCH_WIDTH = 64,
  parameter int unsigned N_ALARMS    = 4,
  parameter logic [7:0]  WRCMD       = 8'h01,
  parameter logic [7:0]  RDCMD       = 8'h02,
  parameter logic [7:0]  STCMD       = 8'h03,
  parameter logic [7:0]  ENCMD       = 8'h04
) (
  input  logic                   clk,
  input  logic                   rst,
  rtc_cmd_if.slave               bus,
  input  logic                   one_hz,
  input  logic                   count_en,
  output logic [EPOCH_WIDTH-1:0] epoch,
  output logic [N_ALARMS-1:0]    alarm_flag,
  output logic                   irq
);
  localparam int unsigned NB    = EPOCH_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  typedef enum logic [2:0] {IDLE, GET_IDX, WR_DATA, RD_DATA, EN_DATA, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   is_wr_q, is_wr_d;
  logic [7:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [EPOCH_WIDTH-1:0] shadow_q, shadow_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic [EPOCH_WIDTH-1:0] alarm_q [N_ALARMS];
  logic [EPOCH_WIDTH-1:0] alarm_d [N_ALARMS];
  logic [N_ALARMS-1:0]    mask_q, mask_d;
  logic [N_ALARMS-1:0]    flag_q, flag_d;
  logic                   chg_q, chg_d;
  logic                   irq_q, irq_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   pend_q, pend_d;

  logic [EPOCH_WIDTH-1:0] rd_val;
  logic [EPOCH_WIDTH-1:0] wr_shift;
  logic [N_ALARMS-1:0]    set_vec;
  logic [N_ALARMS-1:0]    flag_clr;
  logic                   tick;

  assign tick     = one_hz & count_en;
  assign wr_shift = (shadow_q << 8) | EPOCH_WIDTH'(bus.rx_data);

  // Register selected by the index byte currently on rx_data; invalid indices read as all ones.
  always_comb begin
    rd_val = '1;
    if (bus.rx_data == 8'h00) rd_val = epoch_q;
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      if (bus.rx_data == 8'(i + 1)) rd_val = alarm_q[i];
    end
  end

  // Alarm match, evaluated only in the cycle after the epoch was ticked or loaded.
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      set_vec[i] = chg_q & mask_q[i] & (alarm_q[i] == epoch_q);
    end
  end

  // Next-state logic: command decoding, counter update, flag and tx bookkeeping.
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    epoch_d   = epoch_q;
    for (int i = 0; i < int'(N_ALARMS); i++) alarm_d[i] = alarm_q[i];
    mask_d    = mask_q;
    tx_data_d = tx_data_q;
    // A pending byte stays pending only while the shifter is busy.
    pend_d    = pend_q & bus.tx_halt;
    flag_clr  = '0;
    chg_d     = tick;

    if (tick) epoch_d = epoch_q + EPOCH_WIDTH'(1);

    if (!bus.sel) begin
      // Frame ended or aborted: uncommitted write data is simply dropped.
      state_d = IDLE;
    end else if (bus.rx_dv) begin
      tx_data_d = 8'h00;
      pend_d    = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == WRCMD) begin
            is_wr_d = 1'b1;
            state_d = GET_IDX;
          end else if (bus.rx_data == RDCMD) begin
            is_wr_d = 1'b0;
            state_d = GET_IDX;
          end else if (bus.rx_data == ENCMD) begin
            state_d = EN_DATA;
          end else if (bus.rx_data == STCMD) begin
            tx_data_d = 8'(flag_q);
            flag_clr  = flag_q;
            state_d   = DONE;
          end
        end
        GET_IDX: begin
          idx_d = bus.rx_data;
          if (is_wr_q) begin
            cnt_d   = '0;
            state_d = WR_DATA;
          end else begin
            // Whole register captured at once so later ticks cannot tear the read.
            tx_data_d = rd_val[EPOCH_WIDTH-1 -: 8];
            shadow_d  = rd_val << 8;
            cnt_d     = CNT_W'(1);
            state_d   = (NB == 1) ? DONE : RD_DATA;
          end
        end
        WR_DATA: begin
          shadow_d = wr_shift;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NB - 1)) begin
            // A load overrides a same-cycle tick.
            if (idx_q == 8'h00) begin
              epoch_d = wr_shift;
              chg_d   = 1'b1;
            end
            for (int i = 0; i < int'(N_ALARMS); i++) begin
              if (idx_q == 8'(i + 1)) alarm_d[i] = wr_shift;
            end
            state_d = DONE;
          end
        end
        RD_DATA: begin
          tx_data_d = shadow_q[EPOCH_WIDTH-1 -: 8];
          shadow_d  = shadow_q << 8;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NB - 1)) state_d = DONE;
        end
        EN_DATA: begin
          mask_d  = bus.rx_data[N_ALARMS-1:0];
          state_d = DONE;
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end

    // Only flags sampled by the status read clear; a flag setting now survives.
    flag_d = (flag_q & ~flag_clr) | set_vec;
    irq_d  = |flag_q;
  end

  // State register for the FSM, counter, alarms and tx holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      idx_q     <= 8'h00;
      cnt_q     <= '0;
      shadow_q  <= '0;
      epoch_q   <= '0;
      for (int i = 0; i < int'(N_ALARMS); i++) alarm_q[i] <= '0;
      mask_q    <= '0;
      flag_q    <= '0;
      chg_q     <= 1'b0;
      irq_q     <= 1'b0;
      tx_data_q <= 8'h00;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      epoch_q   <= epoch_d;
      for (int i = 0; i < int'(N_ALARMS); i++) alarm_q[i] <= alarm_d[i];
      mask_q    <= mask_d;
      flag_q    <= flag_d;
      chg_q     <= chg_d;
      irq_q     <= irq_d;
      tx_data_q <= tx_data_d;
      pend_q    <= pend_d;
    end
  end

  assign epoch       = epoch_q;
  assign alarm_flag  = flag_q;
  assign irq         = irq_q;
  assign bus.tx_data = tx_data_q;
  // Load strobe fires in the first cycle the shifter is free.
  assign bus.tx_we   = pend_q & ~bus.tx_halt;
endmodule

// File: tb/tb_rtc_cmd_engine.sv
// Self-checking bench for rtc_cmd_engine: directed sequences, a vector table and a random phase.
module tb_rtc_cmd_engine;
  localparam int EW = 64;
  localparam int NA = 4;
  localparam int NB = EW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          one_hz;
  logic          count_en;
  logic [EW-1:0] epoch;
  logic [NA-1:0] alarm_flag;
  logic          irq;

  rtc_cmd_if bus();

  rtc_cmd_engine #(.EPOCH_WIDTH(EW), .N_ALARMS(NA)) dut (
    .clk(clk), .rst(rst), .bus(bus), .one_hz(one_hz), .count_en(count_en),
    .epoch(epoch), .alarm_flag(alarm_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  always @(posedge clk) if (bus.tx_we === 1'b1) we_cnt <= we_cnt + 1;

  logic [7:0] fb [0:31];
  logic [7:0] rb [0:31];
  logic [7:0] exp_rb [0:31];
  int         flen;

  // Reference model state
  logic [EW-1:0] m_epoch;
  logic [EW-1:0] m_alarm [NA];
  logic [NA-1:0] m_mask;
  logic [NA-1:0] m_flags;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [7:0] e0, e1, e2;
  } vec_t;
  vec_t vt [7];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    int k;
    bus.rx_data = b;
    bus.rx_dv   = 1'b1;
    cyc();
    bus.rx_dv = 1'b0;
    k = 0;
    while (bus.tx_we !== 1'b1 && k < 8) begin
      cyc();
      k++;
    end
    chk("tx_we_latency", k, 0);
    r = bus.tx_data;
    cyc();
    cyc();
  endtask

  task automatic run_frame();
    logic [7:0] tmp;
    bus.sel = 1'b1;
    cyc();
    for (int i = 0; i < flen; i++) begin
      send_byte(fb[i], tmp);
      rb[i] = tmp;
    end
    bus.sel = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic wr_reg(input logic [7:0] idx, input logic [EW-1:0] val);
    fb[0] = 8'h01;
    fb[1] = idx;
    for (int k = 0; k < NB; k++) fb[2+k] = 8'(val >> (8 * (NB - 1 - k)));
    flen = 2 + NB;
    run_frame();
  endtask

  task automatic tick_pulse();
    one_hz = 1'b1;
    cyc();
    one_hz = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.sel = 1'b0; bus.rx_dv = 1'b0; bus.rx_data = 8'h00;
    bus.tx_halt = 1'b0; one_hz = 1'b0; count_en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  function automatic logic [EW-1:0] m_reg(input logic [7:0] idx);
    logic [EW-1:0] v;
    v = '1;
    if (idx == 8'h00) v = m_epoch;
    for (int i = 0; i < NA; i++) if (idx == 8'(i + 1)) v = m_alarm[i];
    return v;
  endfunction

  task automatic m_eval();
    for (int i = 0; i < NA; i++) if (m_mask[i] && m_alarm[i] == m_epoch) m_flags[i] = 1'b1;
  endtask

  task automatic m_tick();
    if (count_en) begin
      m_epoch = m_epoch + 1;
      m_eval();
    end
  endtask

  // Frame-level behaviour: one response per byte, effects applied at frame end.
  task automatic model_frame();
    logic [EW-1:0] v;
    logic [7:0]    op, idx;
    for (int i = 0; i < flen; i++) exp_rb[i] = 8'h00;
    op  = fb[0];
    idx = (flen > 1) ? fb[1] : 8'h00;
    if (op == 8'h03) begin
      exp_rb[0] = 8'(m_flags);
      m_flags   = '0;
    end else if (op == 8'h04) begin
      if (flen > 1) m_mask = fb[1][NA-1:0];
    end else if (op == 8'h01) begin
      if (flen >= 2 + NB && idx <= NA) begin
        v = '0;
        for (int k = 0; k < NB; k++) v = (v << 8) | EW'(fb[2+k]);
        if (idx == 0) begin
          m_epoch = v;
          m_eval();
        end else begin
          for (int i = 0; i < NA; i++) if (idx == 8'(i + 1)) m_alarm[i] = v;
        end
      end
    end else if (op == 8'h02 && flen > 1) begin
      v = m_reg(idx);
      for (int k = 0; k < NB && 1 + k < flen; k++) exp_rb[1+k] = 8'(v >> (8 * (NB - 1 - k)));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]    tmp;
    logic [EW-1:0] v;
    int            hw, r;

    vt[0] = '{8'h02, 8'h09, 8'hA5, 8'h00, 8'hFF, 8'hFF};
    vt[1] = '{8'h02, 8'h05, 8'hA5, 8'h00, 8'hFF, 8'hFF};
    vt[2] = '{8'h02, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h00};
    vt[3] = '{8'h7E, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[4] = '{8'h03, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00};
    vt[5] = '{8'hFF, 8'h7E, 8'h03, 8'h00, 8'h00, 8'h00};
    vt[6] = '{8'h04, 8'h01, 8'h77, 8'h00, 8'h00, 8'h00};

    // 1: reset state and plain counting
    do_reset();
    chk("rst_epoch", epoch, 0);
    chk("rst_flags", alarm_flag, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_tx_we", bus.tx_we, 0);
    repeat (3) tick_pulse();
    chk("cnt3_epoch", epoch, 3);
    chk("cnt3_flags", alarm_flag, 0);
    chk("cnt3_irq", irq, 0);
    chk("cnt3_no_we", we_cnt, 0);

    // 2: epoch write then read back MSB first
    wr_reg(8'h00, 64'h1234);
    chk("wr_epoch", epoch, 64'h1234);
    fb[0] = 8'h02; fb[1] = 8'h00;
    for (int k = 0; k < NB; k++) fb[2+k] = 8'hA5;
    flen = 2 + NB;
    run_frame();
    chk("rd_op_resp", rb[0], 8'h00);
    for (int k = 0; k < NB; k++) chk("rd_epoch_byte", rb[1+k], 8'(64'h1234 >> (8 * (NB - 1 - k))));
    chk("rd_done_resp", rb[NB+1], 8'h00);

    // 3: alarm hit, irq timing, read-and-clear
    wr_reg(8'h01, 64'd5);
    fb[0] = 8'h04; fb[1] = 8'h01; flen = 2;
    run_frame();
    wr_reg(8'h00, 64'd4);
    one_hz = 1'b1;
    cyc();
    one_hz = 1'b0;
    chk("al_epoch5", epoch, 5);
    chk("al_flag_early", alarm_flag, 0);
    cyc();
    chk("al_flag_set", alarm_flag, 4'b0001);
    chk("al_irq_early", irq, 0);
    cyc();
    chk("al_irq_set", irq, 1);
    fb[0] = 8'h03; flen = 1;
    run_frame();
    chk("st_resp", rb[0], 8'h01);
    chk("st_cleared", alarm_flag, 0);
    chk("st_irq_drop", irq, 0);

    // 4: wrap, and load winning over a same-cycle tick
    wr_reg(8'h00, '1);
    tick_pulse();
    chk("wrap_epoch", epoch, 0);
    chk("wrap_no_flag", alarm_flag, 0);
    bus.sel = 1'b1;
    cyc();
    fb[0] = 8'h01; fb[1] = 8'h00;
    for (int k = 0; k < NB; k++) fb[2+k] = 8'(64'd7 >> (8 * (NB - 1 - k)));
    for (int i = 0; i < 1 + NB; i++) send_byte(fb[i], tmp);
    bus.rx_data = fb[1+NB]; bus.rx_dv = 1'b1; one_hz = 1'b1;
    cyc();
    bus.rx_dv = 1'b0; one_hz = 1'b0;
    chk("load_vs_tick", epoch, 7);
    cyc(); cyc();
    bus.sel = 1'b0;
    cyc(); cyc();
    count_en = 1'b0;
    tick_pulse();
    chk("count_en_low", epoch, 7);
    count_en = 1'b1;

    // 5: tick in the middle of a read, then a halted tx slot
    bus.sel = 1'b1;
    cyc();
    send_byte(8'h02, tmp);
    send_byte(8'h00, tmp);
    chk("tear_b0", tmp, 8'(64'd7 >> (8 * (NB - 1))));
    for (int k = 1; k < NB; k++) begin
      if (k == 3) begin
        one_hz = 1'b1;
        cyc();
        one_hz = 1'b0;
      end
      send_byte(8'hA5, tmp);
      chk("tear_byte", tmp, 8'(64'd7 >> (8 * (NB - 1 - k))));
    end
    bus.sel = 1'b0;
    cyc(); cyc(); cyc();
    chk("tear_epoch8", epoch, 8);

    bus.sel = 1'b1;
    cyc();
    send_byte(8'h02, tmp);
    bus.tx_halt = 1'b1; bus.rx_data = 8'h00; bus.rx_dv = 1'b1;
    cyc();
    bus.rx_dv = 1'b0;
    hw = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.tx_we !== 1'b0) hw++;
      cyc();
    end
    chk("halt_no_we", hw, 0);
    bus.tx_halt = 1'b0;
    #1;
    chk("halt_we", bus.tx_we, 1);
    chk("halt_data", bus.tx_data, 8'h00);
    cyc();
    chk("halt_we_once", bus.tx_we, 0);
    for (int k = 1; k < NB; k++) send_byte(8'hA5, tmp);
    chk("halt_tail", tmp, 8'h08);
    bus.sel = 1'b0;
    cyc(); cyc(); cyc();

    // 6: aborted write leaves the epoch alone
    fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h33;
    flen = 5;
    run_frame();
    chk("abort_epoch", epoch, 8);

    // Vector table: short frames with fixed responses
    foreach (vt[i]) begin
      fb[0] = vt[i].b0; fb[1] = vt[i].b1; fb[2] = vt[i].b2;
      flen = 3;
      run_frame();
      chk("vec_r0", rb[0], vt[i].e0);
      chk("vec_r1", rb[1], vt[i].e1);
      chk("vec_r2", rb[2], vt[i].e2);
    end
    chk("vec_epoch", epoch, 8);

    // Random phase against the frame-level model
    do_reset();
    m_epoch = '0; m_mask = '0; m_flags = '0;
    for (int i = 0; i < NA; i++) m_alarm[i] = '0;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        count_en = ($urandom_range(0, 3) != 0);
        tick_pulse();
        m_tick();
      end else begin
        r = $urandom_range(0, 9);
        if (r <= 2 || r == 9) begin
          fb[0] = 8'h01;
          fb[1] = 8'($urandom_range(0, NA + 1));
          v = ($urandom_range(0, 1) == 0) ? m_epoch + EW'($urandom_range(1, 3))
                                           : EW'({$urandom, $urandom});
          for (int k = 0; k < NB; k++) fb[2+k] = 8'(v >> (8 * (NB - 1 - k)));
          flen = (r == 9) ? 2 + $urandom_range(0, NB - 1) : 2 + NB;
        end else if (r <= 5) begin
          fb[0] = 8'h02;
          fb[1] = 8'($urandom_range(0, NA + 2));
          for (int k = 0; k < NB + 1; k++) fb[2+k] = 8'($urandom);
          flen = 2 + NB + $urandom_range(0, 1);
        end else if (r == 6) begin
          fb[0] = 8'h03; fb[1] = 8'($urandom);
          flen = $urandom_range(1, 2);
        end else if (r == 7) begin
          fb[0] = 8'h04; fb[1] = 8'($urandom);
          flen = 2;
        end else begin
          fb[0] = 8'($urandom_range(5, 255));
          flen = 1;
        end
        model_frame();
        run_frame();
        for (int i = 0; i < flen; i++) chk("rand_resp", rb[i], exp_rb[i]);
      end
      chk("rand_epoch", epoch, m_epoch);
      chk("rand_flags", alarm_flag, m_flags);
      chk("rand_irq", irq, |m_flags);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
